// File: rtl/letc_core_stage_memory2.sv
// Second memory stage: holds the memory1 payload, waits for the DMSS response,
// extends load data and drives writeback, forwarding and hazard backpressure.
package letc_core_pkg;
  typedef enum logic [1:0] {RD_SRC_ALU = 2'd0, RD_SRC_MEM = 2'd1, RD_SRC_CSR = 2'd2} rd_src_e;
  typedef enum logic [1:0] {MEM_OP_NOP = 2'd0, MEM_OP_LOAD = 2'd1, MEM_OP_STORE = 2'd2} mem_op_e;
  typedef enum logic [1:0] {MEM_SIZE_BYTE = 2'd0, MEM_SIZE_HALF = 2'd1, MEM_SIZE_WORD = 2'd2} mem_size_e;

  typedef struct packed {
    logic [4:0]  rd_idx;
    logic        rd_we;
    rd_src_e     rd_src;
    logic [31:0] alu_result;
    logic [31:0] rs2_val;
    mem_op_e     mem_op;
    mem_size_e   mem_size;
    logic        mem_signed;
    logic        csr_we;
    logic [11:0] csr_idx;
    logic [31:0] csr_old_val;
    logic        sim_exit_req;
  } m1_to_m2_s;

  typedef struct packed {
    m1_to_m2_s   m1;
    logic [31:0] mem_rdata;
  } m2_to_w_s;

  localparam int M1_TO_M2_W = $bits(m1_to_m2_s);
  localparam int M2_TO_W_W  = $bits(m2_to_w_s);
endpackage

module letc_core_stage_memory2
  import letc_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  m2_ready,
  input  logic                  m2_flush,
  input  logic                  m2_stall,
  input  logic                  m1_to_m2_valid,
  input  logic [M1_TO_M2_W-1:0] m1_to_m2,
  input  logic                  dmss1_rsp_valid,
  input  logic [31:0]           dmss1_rsp_rdata,
  output logic                  m2_to_w_valid,
  output logic [M2_TO_W_W-1:0]  m2_to_w,
  output logic                  fwd_instr_produces_rd,
  output logic [4:0]            fwd_rd_idx,
  output logic                  fwd_rd_val_avail,
  output logic [31:0]           fwd_rd_val
);
  typedef enum logic [1:0] {IDLE, WAIT, HAVE, DRAIN} state_e;

  state_e      state;
  m1_to_m2_s   in_next;
  m1_to_m2_s   ff_in;
  logic        ff_in_valid;
  logic [31:0] rsp_q;

  logic        load_mem;
  logic        needs_rsp;
  logic        live_rsp;
  logic        rsp_avail;
  logic [31:0] rsp_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;
  logic [31:0] mem_rdata;
  m2_to_w_s    out;

  assign in_next   = m1_to_m2_s'(m1_to_m2);
  // WAIT is entered at the edge that loads the op, so a response in its first held cycle lands in WAIT.
  assign load_mem  = !m2_stall && !m2_flush && m1_to_m2_valid
                     && (in_next.mem_op == MEM_OP_LOAD || in_next.mem_op == MEM_OP_STORE);
  assign needs_rsp = ff_in_valid && (ff_in.mem_op == MEM_OP_LOAD || ff_in.mem_op == MEM_OP_STORE);
  assign live_rsp  = (state == WAIT) && dmss1_rsp_valid;
  assign rsp_avail = live_rsp || (state == HAVE);
  assign rsp_word  = live_rsp ? dmss1_rsp_rdata : rsp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ff_in       <= '0;
      ff_in_valid <= 1'b0;
      rsp_q       <= '0;
    end else begin
      if (!m2_stall)
        ff_in <= in_next;
      if (m2_flush)
        ff_in_valid <= 1'b0;
      else if (!m2_stall)
        ff_in_valid <= m1_to_m2_valid;

      case (state)
        IDLE: if (load_mem) state <= WAIT;
        WAIT: begin
          if (m2_flush) begin
            state <= dmss1_rsp_valid ? IDLE : DRAIN;
          end else if (dmss1_rsp_valid) begin
            if (m2_stall) begin
              state <= HAVE;
              rsp_q <= dmss1_rsp_rdata;
            end else begin
              state <= load_mem ? WAIT : IDLE;
            end
          end
        end
        HAVE: begin
          if (m2_flush)
            state <= IDLE;
          else if (!m2_stall)
            state <= load_mem ? WAIT : IDLE;
        end
        DRAIN: if (dmss1_rsp_valid) state <= load_mem ? WAIT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    byte_val = rsp_word[{ff_in.alu_result[1:0], 3'b000} +: 8];
    half_val = ff_in.alu_result[1] ? rsp_word[31:16] : rsp_word[15:0];
    case (ff_in.mem_size)
      MEM_SIZE_BYTE: load_val = {{24{ff_in.mem_signed & byte_val[7]}}, byte_val};
      MEM_SIZE_HALF: load_val = {{16{ff_in.mem_signed & half_val[15]}}, half_val};
      default:       load_val = rsp_word;
    endcase
    case (ff_in.mem_op)
      MEM_OP_LOAD:  mem_rdata = load_val;
      MEM_OP_STORE: mem_rdata = rsp_word;
      default:      mem_rdata = 32'h0;
    endcase
    case (ff_in.rd_src)
      RD_SRC_ALU: fwd_rd_val = ff_in.alu_result;
      RD_SRC_MEM: fwd_rd_val = load_val;
      RD_SRC_CSR: fwd_rd_val = ff_in.csr_old_val;
      default:    fwd_rd_val = 32'hDEADBEEF;
    endcase
  end

  assign m2_ready              = !(((state == WAIT) && !dmss1_rsp_valid) || (state == DRAIN));
  assign m2_to_w_valid         = ff_in_valid && !m2_flush && (!needs_rsp || rsp_avail);
  assign out.m1                = ff_in;
  assign out.mem_rdata         = mem_rdata;
  assign m2_to_w               = out;
  assign fwd_instr_produces_rd = ff_in_valid && ff_in.rd_we;
  assign fwd_rd_idx            = ff_in.rd_idx;
  assign fwd_rd_val_avail      = (ff_in.rd_src != RD_SRC_MEM) || rsp_avail;

`ifndef SYNTHESIS
  rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(dmss1_rsp_valid && (state == IDLE || state == HAVE)));
`endif
endmodule

// File: tb/tb_letc_core_stage_memory2.sv
// Bench for letc_core_stage_memory2: transaction-level model checked every cycle,
// plus directed literal expectations.
module tb_letc_core_stage_memory2;
  import letc_core_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  m2_ready;
  logic                  m2_flush;
  logic                  m2_stall;
  logic                  m1_to_m2_valid;
  logic [M1_TO_M2_W-1:0] m1_to_m2;
  logic                  dmss1_rsp_valid;
  logic [31:0]           dmss1_rsp_rdata;
  logic                  m2_to_w_valid;
  logic [M2_TO_W_W-1:0]  m2_to_w;
  logic                  fwd_instr_produces_rd;
  logic [4:0]            fwd_rd_idx;
  logic                  fwd_rd_val_avail;
  logic [31:0]           fwd_rd_val;

  m1_to_m2_s pay;
  m2_to_w_s  w_s;
  assign m1_to_m2 = pay;
  assign w_s      = m2_to_w_s'(m2_to_w);

  int checks = 0;
  int errors = 0;

  letc_core_stage_memory2 dut (
    .clk(clk), .rst_n(rst_n), .m2_ready(m2_ready), .m2_flush(m2_flush), .m2_stall(m2_stall),
    .m1_to_m2_valid(m1_to_m2_valid), .m1_to_m2(m1_to_m2),
    .dmss1_rsp_valid(dmss1_rsp_valid), .dmss1_rsp_rdata(dmss1_rsp_rdata),
    .m2_to_w_valid(m2_to_w_valid), .m2_to_w(m2_to_w),
    .fwd_instr_produces_rd(fwd_instr_produces_rd), .fwd_rd_idx(fwd_rd_idx),
    .fwd_rd_val_avail(fwd_rd_val_avail), .fwd_rd_val(fwd_rd_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the held instruction, whether its response was already received, and a pending discard.
  m1_to_m2_s h;
  logic      h_valid;
  logic      got;
  logic [31:0] got_data;
  logic      drain;

  function automatic logic is_mem(input m1_to_m2_s p);
    return p.mem_op == MEM_OP_LOAD || p.mem_op == MEM_OP_STORE;
  endfunction

  function automatic logic [31:0] model_rdata(input m1_to_m2_s p, input logic [31:0] w);
    logic [31:0] v;
    if (p.mem_op == MEM_OP_STORE) return w;
    if (p.mem_op != MEM_OP_LOAD) return 32'h0;
    if (p.mem_size == MEM_SIZE_BYTE) begin
      v = (w >> (8 * p.alu_result[1:0])) % 256;
      if (p.mem_signed && v >= 128) v = v - 256;
    end else if (p.mem_size == MEM_SIZE_HALF) begin
      v = (p.alu_result[1] ? (w >> 16) : w) % 65536;
      if (p.mem_signed && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      h = '0; h_valid = 1'b0; got = 1'b0; got_data = '0; drain = 1'b0;
    end else begin
      if (drain && dmss1_rsp_valid) drain = 1'b0;
      if (m2_flush) begin
        if (h_valid && is_mem(h) && !got && !dmss1_rsp_valid) drain = 1'b1;
        h_valid = 1'b0;
        got = 1'b0;
      end else if (m2_stall && h_valid && is_mem(h) && !got && dmss1_rsp_valid) begin
        got = 1'b1;
        got_data = dmss1_rsp_rdata;
      end
      if (!m2_stall) begin
        h = pay;
        h_valid = m1_to_m2_valid && !m2_flush;
        got = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic mem_h, avail, e_ready, e_valid, e_favail;
    logic [31:0] word, e_fval;
    if (rst_n) begin
      mem_h    = h_valid && is_mem(h);
      avail    = mem_h && (got || dmss1_rsp_valid);
      word     = got ? got_data : dmss1_rsp_rdata;
      e_ready  = !drain && !(mem_h && !avail);
      e_valid  = h_valid && !m2_flush && (!mem_h || avail);
      e_favail = (h.rd_src != RD_SRC_MEM) || avail;
      chk("m_ready", 32'(m2_ready), 32'(e_ready));
      chk("m_valid", 32'(m2_to_w_valid), 32'(e_valid));
      chk("m_produces", 32'(fwd_instr_produces_rd), 32'(h_valid && h.rd_we));
      chk("m_fwd_avail", 32'(fwd_rd_val_avail), 32'(e_favail));
      if (e_valid) begin
        chk("m_mem_rdata", w_s.mem_rdata, model_rdata(h, word));
        checks++;
        if (w_s.m1 !== h) begin
          errors++;
          $display("FAIL m_passthrough: got %h expected %h", w_s.m1, h);
        end
        $display("m2->w rd=x%0d we=%0b mem_rdata=%h", w_s.m1.rd_idx, w_s.m1.rd_we, w_s.mem_rdata);
      end
      if (h_valid && h.rd_we && e_favail) begin
        case (h.rd_src)
          RD_SRC_ALU: e_fval = h.alu_result;
          RD_SRC_MEM: e_fval = model_rdata(h, word);
          RD_SRC_CSR: e_fval = h.csr_old_val;
          default:    e_fval = 32'hDEADBEEF;
        endcase
        chk("m_fwd_val", fwd_rd_val, e_fval);
        chk("m_fwd_idx", 32'(fwd_rd_idx), 32'(h.rd_idx));
      end
    end
  end

  function automatic m1_to_m2_s mk(input mem_op_e op, input mem_size_e sz, input logic sgn,
                                   input rd_src_e src, input logic [4:0] rd, input logic we,
                                   input logic [31:0] alu);
    m1_to_m2_s p;
    p = '0;
    p.mem_op = op; p.mem_size = sz; p.mem_signed = sgn; p.rd_src = src;
    p.rd_idx = rd; p.rd_we = we; p.alu_result = alu; p.rs2_val = 32'h0BAD_F00D;
    return p;
  endfunction

  task automatic idle_in;
    m1_to_m2_valid = 1'b0; pay = '0; m2_stall = 1'b0; m2_flush = 1'b0;
    dmss1_rsp_valid = 1'b0; dmss1_rsp_rdata = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  mem_size_e   sz_tab  [6] = '{MEM_SIZE_BYTE, MEM_SIZE_BYTE, MEM_SIZE_HALF, MEM_SIZE_HALF, MEM_SIZE_WORD, MEM_SIZE_BYTE};
  logic        sg_tab  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0]  off_tab [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
  logic [31:0] wd_tab  [6] = '{32'h12348567, 32'h12348567, 32'h12348001, 32'h7FFF0000, 32'hCAFEF00D, 32'h0000007F};
  logic [31:0] ex_tab  [6] = '{32'hFFFFFF85, 32'h00000085, 32'hFFFF8001, 32'h00007FFF, 32'hCAFEF00D, 32'h0000007F};

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(m2_ready), 32'd1);
    chk("rst_valid", 32'(m2_to_w_valid), 32'd0);
    chk("rst_produces", 32'(fwd_instr_produces_rd), 32'd0);
    chk("rst_fwd_avail", 32'(fwd_rd_val_avail), 32'd1);
    tick();
    rst_n = 1'b1;

    // ADD x5 = 0x1234
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_NOP, MEM_SIZE_WORD, 1'b0, RD_SRC_ALU, 5'd5, 1'b1, 32'h1234);
    tick(); idle_in();
    @(negedge clk);
    chk("add_valid", 32'(m2_to_w_valid), 32'd1);
    chk("add_fwd_avail", 32'(fwd_rd_val_avail), 32'd1);
    chk("add_fwd_val", fwd_rd_val, 32'h1234);
    tick();

    // LB signed, offset 3, response after 3 cycles
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_LOAD, MEM_SIZE_BYTE, 1'b1, RD_SRC_MEM, 5'd6, 1'b1, 32'h1003);
    tick(); idle_in(); m2_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_wait_ready", 32'(m2_ready), 32'd0);
      chk("lb_wait_valid", 32'(m2_to_w_valid), 32'd0);
      tick();
    end
    m2_stall = 1'b0; dmss1_rsp_valid = 1'b1; dmss1_rsp_rdata = 32'h80FF0000;
    @(negedge clk);
    chk("lb_ready", 32'(m2_ready), 32'd1);
    chk("lb_valid", 32'(m2_to_w_valid), 32'd1);
    chk("lb_rdata", w_s.mem_rdata, 32'hFFFFFF80);
    tick(); idle_in();

    // LHU upper half, response while stalled, then release
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_LOAD, MEM_SIZE_HALF, 1'b0, RD_SRC_MEM, 5'd7, 1'b1, 32'h2002);
    tick(); idle_in(); m2_stall = 1'b1; dmss1_rsp_valid = 1'b1; dmss1_rsp_rdata = 32'hBEEF1234;
    @(negedge clk);
    chk("lhu_live_valid", 32'(m2_to_w_valid), 32'd1);
    tick(); dmss1_rsp_valid = 1'b0; dmss1_rsp_rdata = '0;
    @(negedge clk);
    chk("lhu_held_ready", 32'(m2_ready), 32'd1);
    chk("lhu_held_rdata", w_s.mem_rdata, 32'h0000BEEF);
    tick(); m2_stall = 1'b0;
    @(negedge clk);
    chk("lhu_rel_valid", 32'(m2_to_w_valid), 32'd1);
    chk("lhu_rel_rdata", w_s.mem_rdata, 32'h0000BEEF);
    tick();
    @(negedge clk);
    chk("lhu_after_valid", 32'(m2_to_w_valid), 32'd0);
    chk("lhu_after_ready", 32'(m2_ready), 32'd1);
    tick();

    // SB, response in the first held cycle
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_STORE, MEM_SIZE_BYTE, 1'b0, RD_SRC_ALU, 5'd0, 1'b0, 32'h3001);
    tick(); idle_in(); dmss1_rsp_valid = 1'b1; dmss1_rsp_rdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("sb_valid", 32'(m2_to_w_valid), 32'd1);
    chk("sb_rdata", w_s.mem_rdata, 32'hAABBCCDD);
    chk("sb_rd_we", 32'(w_s.m1.rd_we), 32'd0);
    tick(); idle_in();

    // LW flushed in WAIT, response two cycles later is discarded
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_LOAD, MEM_SIZE_WORD, 1'b0, RD_SRC_MEM, 5'd8, 1'b1, 32'h4000);
    tick(); idle_in(); m2_stall = 1'b1;
    @(negedge clk);
    chk("lwf_wait_ready", 32'(m2_ready), 32'd0);
    chk("lwf_fwd_avail", 32'(fwd_rd_val_avail), 32'd0);
    tick(); m2_flush = 1'b1;
    @(negedge clk);
    chk("lwf_flush_valid", 32'(m2_to_w_valid), 32'd0);
    tick(); m2_flush = 1'b0;
    @(negedge clk);
    chk("lwf_drain_ready", 32'(m2_ready), 32'd0);
    tick(); dmss1_rsp_valid = 1'b1; dmss1_rsp_rdata = 32'h11111111;
    @(negedge clk);
    chk("lwf_rsp_ready", 32'(m2_ready), 32'd0);
    chk("lwf_rsp_valid", 32'(m2_to_w_valid), 32'd0);
    tick(); idle_in();
    @(negedge clk);
    chk("lwf_idle_ready", 32'(m2_ready), 32'd1);
    tick();

    // Flush and response together in WAIT: straight back to IDLE
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_LOAD, MEM_SIZE_WORD, 1'b0, RD_SRC_MEM, 5'd9, 1'b1, 32'h4004);
    tick(); idle_in(); m2_stall = 1'b1; m2_flush = 1'b1; dmss1_rsp_valid = 1'b1; dmss1_rsp_rdata = 32'h22222222;
    @(negedge clk);
    chk("fr_valid", 32'(m2_to_w_valid), 32'd0);
    tick(); idle_in();
    @(negedge clk);
    chk("fr_ready", 32'(m2_ready), 32'd1);
    tick();

    // Back-to-back loads: each response arrives with the next op
    for (int i = 0; i <= 6; i++) begin
      idle_in();
      if (i < 6) begin
        m1_to_m2_valid = 1'b1;
        pay = mk(MEM_OP_LOAD, sz_tab[i], sg_tab[i], RD_SRC_MEM, 5'(10 + i), 1'b1,
                 32'h5000_0000 + 32'(off_tab[i]));
      end
      if (i > 0) begin
        dmss1_rsp_valid = 1'b1; dmss1_rsp_rdata = wd_tab[i-1];
        @(negedge clk);
        chk("b2b_valid", 32'(m2_to_w_valid), 32'd1);
        chk("b2b_rdata", w_s.mem_rdata, ex_tab[i-1]);
      end
      tick();
    end
    idle_in();

    // CSR forwarding and the undefined rd_src default
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_NOP, MEM_SIZE_WORD, 1'b0, RD_SRC_CSR, 5'd20, 1'b1, 32'h0);
    pay.csr_old_val = 32'h55AA;
    tick(); m1_to_m2_valid = 1'b1; pay.rd_src = rd_src_e'(2'd3);
    @(negedge clk);
    chk("csr_fwd_val", fwd_rd_val, 32'h55AA);
    tick(); idle_in();
    @(negedge clk);
    chk("dflt_fwd_val", fwd_rd_val, 32'hDEADBEEF);
    tick();

    // Reset asserted while waiting for a response
    m1_to_m2_valid = 1'b1; pay = mk(MEM_OP_LOAD, MEM_SIZE_WORD, 1'b0, RD_SRC_MEM, 5'd21, 1'b1, 32'h6000);
    tick(); idle_in(); m2_stall = 1'b1;
    @(negedge clk);
    chk("rw_wait_ready", 32'(m2_ready), 32'd0);
    rst_n = 1'b0;
    tick(); idle_in();
    @(negedge clk);
    chk("rw_ready", 32'(m2_ready), 32'd1);
    chk("rw_valid", 32'(m2_to_w_valid), 32'd0);
    chk("rw_produces", 32'(fwd_instr_produces_rd), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/letc_core_stage_memory2.md
# letc_core_stage_memory2

Second memory stage of the LETC core pipeline, between memory1 and writeback. It registers the memory1 payload and waits for the DMSS load/read response. It sign- or zero-extends load data and, for stores, hands the raw read-for-merge word to writeback. It also drives forwarding and the `m2_ready` backpressure signal to the hazard unit.

## Interface
Parameters: none. Widths come from `letc_core_pkg`/`riscv_pkg`.
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; synchronous, active-low
- `m2_ready`  out  1  0 = stage cannot retire its instruction this cycle (hazard unit stalls upstream)
- `m2_flush`  in  1  kill the instruction currently held
- `m2_stall`  in  1  hold the input register
- `m1_to_m2_valid`  in  1  payload valid
- `m1_to_m2`  in  m1_to_m2_s  rd_idx, rd_we, rd_src, alu_result, rs2_val, mem_op, mem_size, mem_signed, csr_*, sim_exit_req
- `dmss1_rsp_valid`  in  1  single-cycle pulse; response for the one outstanding load/store read
- `dmss1_rsp_rdata`  in  32  aligned 32-bit word containing the access
- `m2_to_w_valid`  out  1  payload valid to writeback
- `m2_to_w`  out  m2_to_w_s  m1 fields passed through, plus `mem_rdata`
- `fwd_instr_produces_rd`  out  1  forwarder: held instruction writes rd
- `fwd_rd_idx`  out  5  forwarder: destination register
- `fwd_rd_val_avail`  out  1  forwarder: `fwd_rd_val` is final
- `fwd_rd_val`  out  32  forwarder: rd value

## Operation
- Input register `ff_in`/`ff_in_valid` loads when `!m2_stall`.
- `ff_in_valid` loads `m1_to_m2_valid && !m2_flush`. It clears on reset.
- `needs_rsp` = `ff_in_valid && mem_op ∈ {LOAD, STORE}`.
- FSM states:
  - IDLE: no response held.
  - WAIT: `needs_rsp`, response not yet seen.
  - HAVE: response captured into `rsp_q`, instruction not yet advanced.
  - DRAIN: instruction flushed while its response is still outstanding.
- Transitions:
  - IDLE→WAIT when a mem op is loaded into `ff_in`. If `dmss1_rsp_valid` arrives in the same cycle the op is first held, the data is used directly and captured.
  - WAIT→HAVE on `dmss1_rsp_valid` while `m2_stall`. WAIT→IDLE on `dmss1_rsp_valid && !m2_stall`.
  - HAVE→IDLE when `!m2_stall`.
  - WAIT + `m2_flush` → DRAIN. DRAIN→IDLE on `dmss1_rsp_valid`; that data is discarded.
  - HAVE + `m2_flush` → IDLE.
- `rsp_avail` = `dmss1_rsp_valid` (in WAIT) or state == HAVE. The live response has priority over `rsp_q`.
- `m2_ready` = 0 in WAIT without `dmss1_rsp_valid`. `m2_ready` = 0 in DRAIN. Otherwise 1.
- `m2_to_w_valid` = `ff_in_valid && !m2_flush && (!needs_rsp || rsp_avail)`.
- Load data: `off = alu_result[1:0]`, `w` = response word.
  - BYTE: `b = w[8*off +: 8]`, extended by `mem_signed` (sign) or zero.
  - HALFWORD: `h = alu_result[1] ? w[31:16] : w[15:0]`, extended likewise.
  - WORD: `w` unchanged.
- STORE: `mem_rdata` = raw `w`, used for merging. For non-mem ops, `mem_rdata` = 0.
- Forwarding:
  - `fwd_instr_produces_rd` = `ff_in_valid && rd_we`.
  - `fwd_rd_val_avail` = `rd_src != RD_SRC_MEM || rsp_avail`.
  - `fwd_rd_val` selects by `rd_src`: alu_result, extended load, or csr_old_val. Default 32'hDEADBEEF.
- Only one outstanding response is legal. A `dmss1_rsp_valid` in IDLE or HAVE is a protocol error (SIMULATION assertion).

## Timing
- Reset values:
  - state IDLE, `ff_in_valid` 0.
  - `m2_ready` 1, `m2_to_w_valid` 0.
  - `fwd_instr_produces_rd` 0, `fwd_rd_val_avail` 1.
- Non-mem op: 1 cycle in the stage, combinational to writeback.
- Mem op: valid in the first cycle `rsp_avail` holds. Zero added cycles if the response arrives in the first held cycle.
- `m2_ready` is combinational from state and `dmss1_rsp_valid`.
- Flush has priority over stall and over valid.
- Reset mid-WAIT or mid-DRAIN returns to IDLE. DMSS is reset in the same cycle, so no stale response follows.
- Response arriving in the same cycle as `m2_flush` while in WAIT: discarded, state goes to IDLE, never DRAIN.

## Test plan
- ADD x5 result 0x1234 with no stall → `m2_to_w_valid` 1 the cycle after capture, `fwd_rd_val_avail` 1, `fwd_rd_val` 0x1234.
- LB, `alu_result[1:0]`=2'b11, signed, response 0x80FF_0000 delayed 3 cycles → `m2_ready` 0 for 3 cycles, then `mem_rdata` 0xFFFFFF80 with valid 1.
- LHU, `alu_result[1]`=1, response 0xBEEF_1234 arrives while `m2_stall`=1 → state HAVE. After stall drops: `mem_rdata` 0x0000BEEF, then IDLE.
- SB with response 0xAABBCCDD → `mem_rdata` 0xAABBCCDD passed unmodified, `rd_we` passthrough.
- LW flushed in WAIT, response arrives 2 cycles later → DRAIN, no `m2_to_w_valid`, `m2_ready` 0 until the response, then IDLE with `m2_ready` 1.
- Reset asserted in WAIT → next cycle: IDLE, `m2_ready` 1, `m2_to_w_valid` 0.
